adc_sample_fifo: RTL

Parametrised synchronous FIFO for ADC sample buffering: wraps a simple dual-port block RAM with write/read pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. Sits between the ADC front-end sample capture and the packetiser/transmit path. Replaces the fixed 64x16 bare RAM, where pointer and flag handling was done outside the memory.

---
 rtl/adc_fifo_pkg.sv | 12 +
 rtl/adc_fifo_ram.sv | 38 +++
 rtl/adc_sample_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adc_fifo_pkg.sv
// Shared constants and helpers for the ADC sample FIFO.
package adc_fifo_pkg;

    localparam int unsigned WIDTH_DEF      = 16;
    localparam int unsigned DEPTH_LOG2_DEF = 6;

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/adc_fifo_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port with enable.
module adc_fifo_ram #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register reset maps onto the block RAM's synchronous output reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO: pointers, occupancy count, registered status flags
// and sticky overflow/underflow errors around a dual-port RAM.
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int unsigned AFULL_LEVEL  = 48,
    parameter int unsigned AEMPTY_LEVEL = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  WEN,
    input  logic [WIDTH-1:0]      WD,
    input  logic                  REN,
    output logic [WIDTH-1:0]      RD,
    output logic                  RD_VALID,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    localparam int unsigned CW    = count_width(DEPTH_LOG2);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO never takes a write
    // on the strength of a same-cycle read (and likewise for empty).
    assign wr_acc = WEN & ~full_q  & ~FLUSH;
    assign rd_acc = REN & ~empty_q & ~FLUSH;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rvalid_d = rd_acc;
        ovf_d    = ovf_q & ~CLR_ERR;
        unf_d    = unf_q & ~CLR_ERR;

        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + DEPTH_LOG2'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + DEPTH_LOG2'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
            if (WEN && full_q) begin
                ovf_d = 1'b1;
            end
            if (REN && empty_q) begin
                unf_d = 1'b1;
            end
        end

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_LEVEL));
        aempty_d = (count_d <= CW'(AEMPTY_LEVEL));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AFULL_LEVEL == 0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rvalid_q <= rvalid_d;
        end
    end

    adc_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (WD),
        .re_i    (rd_acc),
        .raddr_i (rptr_q),
        .rdata_o (RD)
    );

    assign RD_VALID     = rvalid_q;
    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule
